reg_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing the write side of a bank of my_register instances among NUM_REQ requesters.

---
 rtl/reg_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter for the write port of a register bank.
//               It picks at most one of NUM_REQ requesters per cycle. It then
//               drives a one-hot write enable and the shared write data to the
//               bank, and returns a one-hot grant to the winning requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i         in   1                   clock, rising edge
//   reset_i       in   1                   synchronous active-high reset
//   req_i         in   NUM_REQ             per-requester write request
//   addr_i        in   NUM_REQ*ADDR_WIDTH  packed register index per requester
//   data_i        in   NUM_REQ*DATA_WIDTH  packed write data per requester
//   grant_o       out  NUM_REQ             one-hot grant (registered)
//   write_en_o    out  NUM_REGS            one-hot bank write enable (registered)
//   write_data_o  out  DATA_WIDTH          bank write data (registered)
//   addr_err_o    out  1                   granted address out of range (registered)
//   busy_o        out  1                   a grant is being presented this cycle
// ============================================================================
module reg_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REGS   = 4,
  localparam int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    data_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic [NUM_REGS-1:0]              write_en_o,
  output logic [DATA_WIDTH-1:0]            write_data_o,
  output logic                             addr_err_o,
  output logic                             busy_o
);

  localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic [PTR_WIDTH-1:0]    r_ptr;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REGS-1:0]     r_wen;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_err;

  // --------------------------------------------------------------------------
  // Combinational next values
  // --------------------------------------------------------------------------
  state_t                  w_state_nxt;
  logic [PTR_WIDTH-1:0]    w_ptr_nxt;
  logic [NUM_REQ-1:0]      w_grant_nxt;
  logic [NUM_REGS-1:0]     w_wen_nxt;
  logic [DATA_WIDTH-1:0]   w_wdata_nxt;
  logic                    w_err_nxt;

  logic [NUM_REQ-1:0]      w_elig;
  logic                    w_found;
  logic [PTR_WIDTH-1:0]    w_sel;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_addr_ok;
  logic [NUM_REGS-1:0]     w_dec;

  // The requester holding the current grant only sees grant_o after this
  // edge, so its request is still up; masking it avoids a double grant.
  assign w_elig = req_i & ~r_grant;

  // Rotating search starting at the priority pointer: first eligible wins.
  always_comb begin : p_search
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_sel   = PTR_WIDTH'(idx);
      end
    end
  end

  assign w_sel_addr = addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_data = data_i[w_sel*DATA_WIDTH +: DATA_WIDTH];

  // The index field may encode more values than the bank has registers.
  assign w_addr_ok  = (int'(w_sel_addr) < NUM_REGS);

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_wen_dec
      assign w_dec[i] = w_addr_ok && (int'(w_sel_addr) == i);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    w_state_nxt = ST_IDLE;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = '0;
    w_wen_nxt   = '0;
    w_err_nxt   = 1'b0;
    w_wdata_nxt = r_wdata;   // write data is held while idle

    if (w_found) begin
      w_state_nxt = ST_GRANT;
      for (int r = 0; r < NUM_REQ; r++) begin
        w_grant_nxt[r] = (int'(w_sel) == r);
      end
      // An out-of-range write is still granted so the requester never stalls;
      // it simply reaches no register and is flagged instead.
      w_wen_nxt   = w_dec;
      w_err_nxt   = ~w_addr_ok;
      w_wdata_nxt = w_sel_data;
      w_ptr_nxt   = (int'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin : p_state
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_wen   <= w_wen_nxt;
      r_wdata <= w_wdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign grant_o      = r_grant;
  assign write_en_o   = r_wen;
  assign write_data_o = r_wdata;
  assign addr_err_o   = r_err;
  // GRANT state coincides exactly with a non-zero grant_o.
  assign busy_o       = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter. A table of directed
//               vectors covers reset, rotation, wrap-around, held requests and
//               a single remapped write. Hand-written sequences cover reset
//               during a grant and out-of-range addresses on a 3-register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  addr;
  logic [15:0] data;

  logic [3:0]  grant;
  logic [3:0]  wen;
  logic [3:0]  wdata;
  logic        err;
  logic        busy;

  logic [3:0]  grant3;
  logic [2:0]  wen3;
  logic [3:0]  wdata3;
  logic        err3;
  logic        busy3;

  int n_checks = 0;
  int n_fail   = 0;

  reg_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .NUM_REGS(4)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        (req),
    .addr_i       (addr),
    .data_i       (data),
    .grant_o      (grant),
    .write_en_o   (wen),
    .write_data_o (wdata),
    .addr_err_o   (err),
    .busy_o       (busy)
  );

  reg_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .NUM_REGS(3)) dut3 (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        (req),
    .addr_i       (addr),
    .data_i       (data),
    .grant_o      (grant3),
    .write_en_o   (wen3),
    .write_data_o (wdata3),
    .addr_err_o   (err3),
    .busy_o       (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [3:0]  g;
    logic [3:0]  we;
    logic [3:0]  wd;
    logic        err;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge sample them, then settle off-edge.
  task automatic cycle(input logic r, input logic [3:0] q,
                       input logic [7:0] a, input logic [15:0] d);
    reset = r;
    req   = q;
    addr  = a;
    data  = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    addr  = '0;
    data  = '0;

    // addr 8'hE4: r0->0 r1->1 r2->2 r3->3 ; data 16'hC965: r0=5 r1=6 r2=9 r3=C
    //            rst   req      addr   data       grant    wen      wd    err
    vecs[0]  = '{1'b1, 4'b1111, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 4'b1111, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'h0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'h0, 1'b0};
    // Fair rotation: each requester drops on its grant, re-raises a cycle later
    vecs[4]  = '{1'b0, 4'b1111, 8'hE4, 16'hC965, 4'b0001, 4'b0001, 4'h5, 1'b0};
    vecs[5]  = '{1'b0, 4'b1110, 8'hE4, 16'hC965, 4'b0010, 4'b0010, 4'h6, 1'b0};
    vecs[6]  = '{1'b0, 4'b1101, 8'hE4, 16'hC965, 4'b0100, 4'b0100, 4'h9, 1'b0};
    vecs[7]  = '{1'b0, 4'b1011, 8'hE4, 16'hC965, 4'b1000, 4'b1000, 4'hC, 1'b0};
    vecs[8]  = '{1'b0, 4'b0111, 8'hE4, 16'hC965, 4'b0001, 4'b0001, 4'h5, 1'b0};
    // Idle: data held
    vecs[9]  = '{1'b0, 4'b0000, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'h5, 1'b0};
    // Wrap-around: r3 then {r3,r0} -> r0 then r3
    vecs[10] = '{1'b0, 4'b1000, 8'hE4, 16'hC965, 4'b1000, 4'b1000, 4'hC, 1'b0};
    vecs[11] = '{1'b0, 4'b1001, 8'hE4, 16'hC965, 4'b0001, 4'b0001, 4'h5, 1'b0};
    vecs[12] = '{1'b0, 4'b1001, 8'hE4, 16'hC965, 4'b1000, 4'b1000, 4'hC, 1'b0};
    vecs[13] = '{1'b0, 4'b0000, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'hC, 1'b0};
    // Held request from r1 alternates
    vecs[14] = '{1'b0, 4'b0010, 8'hE4, 16'hC965, 4'b0010, 4'b0010, 4'h6, 1'b0};
    vecs[15] = '{1'b0, 4'b0010, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'h6, 1'b0};
    vecs[16] = '{1'b0, 4'b0010, 8'hE4, 16'hC965, 4'b0010, 4'b0010, 4'h6, 1'b0};
    vecs[17] = '{1'b0, 4'b0010, 8'hE4, 16'hC965, 4'b0000, 4'b0000, 4'h6, 1'b0};
    // Single request r2 -> reg 3, data A, then data held
    vecs[18] = '{1'b0, 4'b0100, 8'hF4, 16'hCA65, 4'b0100, 4'b1000, 4'hA, 1'b0};
    vecs[19] = '{1'b0, 4'b0000, 8'hF4, 16'hCA65, 4'b0000, 4'b0000, 4'hA, 1'b0};

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rst, vecs[i].req, vecs[i].addr, vecs[i].data);
      chk("grant", i, 16'(grant), 16'(vecs[i].g));
      chk("wen",   i, 16'(wen),   16'(vecs[i].we));
      chk("wdata", i, 16'(wdata), 16'(vecs[i].wd));
      chk("err",   i, 16'(err),   16'(vecs[i].err));
      chk("busy",  i, 16'(busy),  16'(vecs[i].g != 4'b0000));
    end

    // Reset asserted in a grant cycle drops the write and the pointer.
    cycle(1'b1, 4'b0000, 8'hE4, 16'hC965);
    chk("rst_grant", 100, 16'(grant), 16'h0);
    cycle(1'b0, 4'b0100, 8'hE4, 16'hC965);
    chk("pre_grant", 101, 16'(grant), 16'h4);
    chk("pre_wdata", 101, 16'(wdata), 16'h9);
    cycle(1'b1, 4'b1111, 8'hE4, 16'hC965);
    chk("midrst_grant", 102, 16'(grant), 16'h0);
    chk("midrst_wen",   102, 16'(wen),   16'h0);
    chk("midrst_wdata", 102, 16'(wdata), 16'h0);
    chk("midrst_err",   102, 16'(err),   16'h0);
    chk("midrst_busy",  102, 16'(busy),  16'h0);
    cycle(1'b0, 4'b1111, 8'hE4, 16'hC965);
    chk("ptr0_grant", 103, 16'(grant), 16'h1);
    chk("ptr0_wdata", 103, 16'(wdata), 16'h5);
    cycle(1'b0, 4'b0000, 8'hE4, 16'hC965);
    chk("idle_grant", 104, 16'(grant), 16'h0);

    // Out-of-range index on the 3-register bank; in range on the 4-register one.
    cycle(1'b0, 4'b0001, 8'h03, 16'h0007);
    chk("oor_grant3", 105, 16'(grant3), 16'h1);
    chk("oor_wen3",   105, 16'(wen3),   16'h0);
    chk("oor_err3",   105, 16'(err3),   16'h1);
    chk("oor_wdata3", 105, 16'(wdata3), 16'h7);
    chk("oor_busy3",  105, 16'(busy3),  16'h1);
    chk("inr_wen",    105, 16'(wen),    16'h8);
    chk("inr_err",    105, 16'(err),    16'h0);
    cycle(1'b0, 4'b0000, 8'h03, 16'h0007);
    chk("post_err3",   106, 16'(err3),   16'h0);
    chk("post_grant3", 106, 16'(grant3), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
